// File: rtl/video_pattern_gen.sv
// Video test-pattern source: raster timing, sync, colour bars, ramp,
// checkerboard and solid fill, one registered pixel per clock.
module video_pattern_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CHK_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  pattern,
  input  logic [23:0] solid_rgb,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        dv,
  output logic        hs,
  output logic        vs,
  output logic        sof,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
  localparam logic [15:0] HS_BEG   = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_BEG   = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] BAR_LAST = 16'(BAR_W - 1);

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHK   = 2'd2,
    PAT_SOLID = 2'd3
  } pat_e;

  logic [15:0] hcnt_q, hcnt_d;
  logic [15:0] vcnt_q, vcnt_d;
  logic [15:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]  bar_idx_q, bar_idx_d;
  pat_e        pat_q, pat_d;
  logic [23:0] col_q, col_d;
  logic [23:0] rgb_q, rgb_d;
  logic        dv_q, dv_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        sof_q, sof_d;
  logic [15:0] fcnt_q, fcnt_d;

  logic        origin;
  logic        h_last;
  logic        v_last;
  pat_e        pat_cur;
  logic [23:0] col_cur;
  logic [23:0] pix;

  always_comb begin
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    pat_d     = pat_q;
    col_d     = col_q;
    fcnt_d    = fcnt_q;
    rgb_d     = '0;
    dv_d      = 1'b0;
    hs_d      = ~HS_POL;
    vs_d      = ~VS_POL;
    sof_d     = 1'b0;

    origin  = (hcnt_q == '0) && (vcnt_q == '0);
    h_last  = (hcnt_q == H_LAST);
    v_last  = (vcnt_q == V_LAST);
    // The frame's first pixel already uses the freshly latched settings
    pat_cur = origin ? pat_e'(pattern) : pat_q;
    col_cur = origin ? solid_rgb : col_q;

    pix = '0;
    unique case (pat_cur)
      PAT_BARS: begin
        unique case (bar_idx_q)
          3'd0: pix = 24'hFFFFFF;
          3'd1: pix = 24'hFFFF00;
          3'd2: pix = 24'h00FFFF;
          3'd3: pix = 24'h00FF00;
          3'd4: pix = 24'hFF00FF;
          3'd5: pix = 24'hFF0000;
          3'd6: pix = 24'h0000FF;
          3'd7: pix = 24'h000000;
        endcase
      end
      PAT_RAMP:  pix = {3{hcnt_q[7:0]}};
      PAT_CHK:   pix = (hcnt_q[CHK_LOG2] ^ vcnt_q[CHK_LOG2]) ?
                       24'hFFFFFF : 24'h000000;
      PAT_SOLID: pix = col_cur;
    endcase

    if (!en) begin
      hcnt_d    = '0;
      vcnt_d    = '0;
      bar_cnt_d = '0;
      bar_idx_d = '0;
    end else begin
      if (origin) begin
        pat_d = pat_cur;
        col_d = col_cur;
      end
      dv_d  = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
      rgb_d = dv_d ? pix : '0;
      hs_d  = (hcnt_q >= HS_BEG && hcnt_q < HS_END) ? HS_POL : ~HS_POL;
      vs_d  = (vcnt_q >= VS_BEG && vcnt_q < VS_END) ? VS_POL : ~VS_POL;
      sof_d = origin;
      if (h_last) begin
        hcnt_d    = '0;
        bar_cnt_d = '0;
        bar_idx_d = '0;
        vcnt_d    = v_last ? '0 : vcnt_q + 16'd1;
        if (v_last) fcnt_d = fcnt_q + 16'd1;
      end else begin
        hcnt_d = hcnt_q + 16'd1;
        if (bar_cnt_q == BAR_LAST) begin
          bar_cnt_d = '0;
          bar_idx_d = bar_idx_q + 3'd1;
        end else begin
          bar_cnt_d = bar_cnt_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      pat_q     <= PAT_BARS;
      col_q     <= '0;
      rgb_q     <= '0;
      dv_q      <= 1'b0;
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      sof_q     <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      pat_q     <= pat_d;
      col_q     <= col_d;
      rgb_q     <= rgb_d;
      dv_q      <= dv_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      sof_q     <= sof_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign red       = rgb_q[23:16];
  assign green     = rgb_q[15:8];
  assign blue      = rgb_q[7:0];
  assign dv        = dv_q;
  assign hs        = hs_q;
  assign vs        = vs_q;
  assign sof       = sof_q;
  assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen on a 24x8 raster,
// with a second instance checking inverted hs polarity.
module tb_video_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  pattern;
  logic [23:0] solid_rgb;
  logic [7:0]  red, green, blue;
  logic        dv, hs, vs, sof;
  logic [15:0] frame_cnt;
  logic [7:0]  red2, green2, blue2;
  logic        dv2, hs2, vs2, sof2;
  logic [15:0] frame_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  video_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CHK_LOG2(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .pattern(pattern), .solid_rgb(solid_rgb),
    .red(red), .green(green), .blue(blue),
    .dv(dv), .hs(hs), .vs(vs), .sof(sof),
    .frame_cnt(frame_cnt)
  );

  video_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .CHK_LOG2(1)
  ) dut_n (
    .clk(clk), .rst(rst), .en(en),
    .pattern(pattern), .solid_rgb(solid_rgb),
    .red(red2), .green(green2), .blue(blue2),
    .dv(dv2), .hs(hs2), .vs(vs2), .sof(sof2),
    .frame_cnt(frame_cnt2)
  );

  typedef struct {
    logic [23:0] rgb;
    logic        dv;
    logic        hs;
    logic        hs_n;
    logic        vs;
    logic        sof;
    logic [15:0] fc;
  } exp_t;

  exp_t sb[$];

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF,
                            24'h00FF00, 24'hFF00FF, 24'hFF0000,
                            24'h0000FF, 24'h000000};

  int          m_h, m_v;
  logic [15:0] m_fc;
  logic [1:0]  m_pat;
  logic [23:0] m_col;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] model_pix(input int h, input int v,
                                            input logic [1:0] p,
                                            input logic [23:0] c);
    logic [31:0] hv;
    hv = 32'(h);
    case (p)
      2'd0:    return bars[h / 2];
      2'd1:    return {3{hv[7:0]}};
      2'd2:    return (((h >> 1) ^ (v >> 1)) & 1) != 0 ? 24'hFFFFFF : 24'h0;
      default: return c;
    endcase
  endfunction

  task automatic model_reset();
    m_h = 0; m_v = 0; m_fc = '0; m_pat = '0; m_col = '0;
  endtask

  task automatic step();
    exp_t e;
    logic org;
    e.rgb = '0; e.dv = 1'b0; e.hs = 1'b0; e.hs_n = 1'b1;
    e.vs = 1'b0; e.sof = 1'b0;
    if (!en) begin
      m_h = 0;
      m_v = 0;
    end else begin
      org = (m_h == 0) && (m_v == 0);
      if (org) begin
        m_pat = pattern;
        m_col = solid_rgb;
      end
      e.dv   = (m_h < 16) && (m_v < 4);
      e.rgb  = e.dv ? model_pix(m_h, m_v, m_pat, m_col) : 24'h0;
      e.hs   = (m_h >= 18) && (m_h < 21);
      e.hs_n = ~e.hs;
      e.vs   = (m_v >= 5) && (m_v < 7);
      e.sof  = org;
      if (m_h == 23) begin
        m_h = 0;
        if (m_v == 7) begin
          m_v = 0;
          m_fc = m_fc + 16'd1;
        end else begin
          m_v = m_v + 1;
        end
      end else begin
        m_h = m_h + 1;
      end
    end
    e.fc = m_fc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("rgb", {8'h0, red, green, blue}, {8'h0, e.rgb});
    chk("dv", 32'(dv), 32'(e.dv));
    chk("hs", 32'(hs), 32'(e.hs));
    chk("hs_neg", 32'(hs2), 32'(e.hs_n));
    chk("vs", 32'(vs), 32'(e.vs));
    chk("sof", 32'(sof), 32'(e.sof));
    chk("frame_cnt", 32'(frame_cnt), 32'(e.fc));
  endtask

  initial begin
    int n_dv, n_hs, n_hs_rise, n_vs, vs_first, n_solid;
    logic hs_prev;
    logic [15:0] fc_save;

    rst = 1'b1; en = 1'b0; pattern = 2'd0; solid_rgb = '0;
    model_reset();
    #12;
    chk("rst_rgb", {8'h0, red, green, blue}, 32'h0);
    chk("rst_dv", 32'(dv), 32'h0);
    chk("rst_hs", 32'(hs), 32'h0);
    chk("rst_hs_neg", 32'(hs2), 32'h1);
    chk("rst_vs", 32'(vs), 32'h0);
    chk("rst_sof", 32'(sof), 32'h0);
    chk("rst_fc", 32'(frame_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;

    n_dv = 0; n_hs = 0; n_hs_rise = 0; n_vs = 0; vs_first = -1;
    hs_prev = 1'b0;
    for (int i = 0; i < 192; i++) begin
      step();
      if (i == 0) begin
        chk("first_sof", 32'(sof), 32'h1);
        chk("first_pix", {8'h0, red, green, blue}, 32'hFFFFFF);
      end
      if (i == 2 || i == 3)
        chk("bar1_pix", {8'h0, red, green, blue}, 32'hFFFF00);
      if (i == 15)
        chk("bar7_pix", {8'h0, red, green, blue}, 32'h000000);
      if (dv) n_dv++;
      if (hs) n_hs++;
      if (hs && !hs_prev) n_hs_rise++;
      hs_prev = hs;
      if (vs) begin
        n_vs++;
        if (vs_first < 0) vs_first = i;
      end
    end
    chk("dv_per_frame", 32'(n_dv), 32'd64);
    chk("hs_clocks", 32'(n_hs), 32'd24);
    chk("hs_pulses", 32'(n_hs_rise), 32'd8);
    chk("vs_clocks", 32'(n_vs), 32'd48);
    chk("vs_start", 32'(vs_first), 32'd120);
    chk("fc_after_frame", 32'(frame_cnt), 32'd1);

    pattern = 2'd1;
    for (int i = 0; i < 192; i++) begin
      step();
      if (i < 16) chk("ramp_pix", {8'h0, red, green, blue}, 32'(i * 32'h010101));
    end

    pattern = 2'd2;
    for (int i = 0; i < 192; i++) begin
      step();
      if (i == 2) chk("chk_row0", {8'h0, red, green, blue}, 32'hFFFFFF);
      if (i == 48) chk("chk_row2", {8'h0, red, green, blue}, 32'hFFFFFF);
    end

    pattern = 2'd0;
    for (int i = 0; i < 192; i++) begin
      if (i == 50) begin
        pattern   = 2'd3;
        solid_rgb = 24'h123456;
      end
      step();
      if (i == 72) chk("bars_kept", {8'h0, red, green, blue}, 32'hFFFFFF);
    end
    n_solid = 0;
    for (int i = 0; i < 192; i++) begin
      step();
      if (dv && {red, green, blue} == 24'h123456) n_solid++;
    end
    chk("solid_frame", 32'(n_solid), 32'd64);

    for (int i = 0; i < 200 && !(m_h == 7 && m_v == 1); i++) step();
    chk("abort_pos", 32'(m_h * 100 + m_v), 32'd701);
    fc_save = frame_cnt;
    en = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("abort_fc", 32'(frame_cnt), 32'(fc_save));
    chk("abort_dv", 32'(dv), 32'h0);
    en = 1'b1;
    step();
    chk("resume_sof", 32'(sof), 32'h1);

    step();
    step();
    chk("pre_rst_dv", 32'(dv), 32'h1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_rgb", {8'h0, red, green, blue}, 32'h0);
    chk("arst_dv", 32'(dv), 32'h0);
    chk("arst_hs", 32'(hs), 32'h0);
    chk("arst_hs_neg", 32'(hs2), 32'h1);
    chk("arst_vs", 32'(vs), 32'h0);
    chk("arst_fc", 32'(frame_cnt), 32'h0);
    model_reset();
    #2;
    rst = 1'b0;
    pattern = 2'd2;
    for (int i = 0; i < 192; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
